div_32bit: RTL
==============

# div_32bit

Multi-cycle 32-bit integer divider, the inverse-direction companion of the 32-bit adder in the CPU datapath. Accepts dividend/divisor on a start strobe, performs restoring division one quotient bit per clock using a 32-bit subtract stage, and returns quotient, remainder and exception flags with a one-cycle done pulse. Sits beside the ALU and is sequenced by the control unit for DIV/DIVU.

## Interface
Parameters:
- none; width fixed at 32 by package constant.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  request strobe, sampled only while Busy=0
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start
- A  in  32  dividend, sampled with Start
- B  in  32  divisor, sampled with Start
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse, results valid
- Q  out  32  quotient
- R  out  32  remainder
- DivZero  out  1  B was zero
- Overflow  out  1  signed 0x80000000 / 0xFFFFFFFF

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: Start=1 latches A, B, Signed; -> PREP; Busy=1.
- PREP (1 cycle): B==0 -> Q=0xFFFFFFFF, R=A, DivZero=1, -> IDLE with Done. Signed and A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, Overflow=1, -> IDLE with Done. Otherwise load magnitudes (abs when signed), clear 33-bit partial remainder, counter=31, -> ITER.
- ITER (32 cycles): shift {rem, dividend} left 1; trial = rem - |B| (33-bit); non-negative -> keep, quotient bit 1; else restore, bit 0. Counter decrements; at 0 -> FIX.
- FIX (1 cycle): signed only -- negate Q if sign(A)!=sign(B); negate R if A negative (truncate toward zero, remainder takes dividend sign). Register Q/R, Done=1, -> IDLE.
- Flags clear on every accepted Start; Q, R, flags hold until next accepted Start.
- Start while Busy=1: ignored, no queueing.

## Timing
- Start sampled at edge k: Busy=1 after k; normal result: Done=1 and Busy=0 for cycle after edge k+34.
- Exception result: Done after edge k+2.
- Done never asserted in consecutive cycles; back-to-back Start allowed in the cycle Done is high (Busy=0).
- Reset (any time, including mid-ITER): state IDLE, Busy=0, Done=0, Q=0, R=0, DivZero=0, Overflow=0; in-flight operation discarded, no Done.

## Configuration
- DIV_SIGNED_EN defined: Signed port honoured, abs/negate logic and Overflow detection present.
- Undefined: Signed ignored, all operations unsigned, FIX is a pass-through cycle (latency unchanged), Overflow tied 0.

## Structure
- Package div_pkg: WIDTH=32, state encoding (IDLE, PREP, ITER, FIX), counter width 5, DIVZERO quotient constant 0xFFFFFFFF.
- Sub-module sub_33bit: combinational 33-bit subtract with borrow-out, used for the trial subtraction.

## Test plan
- Unsigned A=100, B=7 -> Done at k+34, Q=14, R=2, flags 0.
- Unsigned A=0x939B9593, B=0x53D49755 -> Q=1, R=0x3FC6FE3E.
- Signed A=-7 (0xFFFFFFF9), B=2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF; with DIV_SIGNED_EN undefined -> Q=0x7FFFFFFC, R=1.
- A=5, B=0 -> Done at k+2, Q=0xFFFFFFFF, R=5, DivZero=1; signed A=0x80000000, B=0xFFFFFFFF -> Done at k+2, Q=0x80000000, R=0, Overflow=1.
- Start pulsed at k+10 of running op with different operands -> ignored, first result unchanged at k+34.
- rst_n low at k+20 -> all outputs 0 immediately, no Done; new Start after release -> correct result 34 cycles later.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle 32-bit divider: data width, FSM encoding,
// iteration counter width and the divide-by-zero quotient.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PREP = 2'd1;
  localparam state_t ST_ITER = 2'd2;
  localparam state_t ST_FIX  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIVZERO_Q = '1;
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement negate when neg is set; also serves as abs() for operands.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/sub_33bit.sv
// Combinational 33-bit subtractor with borrow-out, used as the trial-subtract
// stage of the restoring divider.
module sub_33bit (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] diff,
  output logic        borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_32bit.sv
// Multi-cycle restoring divider, one quotient bit per clock (IDLE/PREP/ITER/FIX).
// Build with DIV_SIGNED_EN defined to honour the Signed port and detect Overflow.
module div_32bit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivZero,
  output logic             Overflow,
  output state_t           dbg_state
);

  // Handshake: Start is accepted only on a clock edge where Busy=0; Busy rises
  // right after that edge and stays high until the cycle Done pulses (Done and
  // Busy=0 coincide, so a new Start may be presented in that same cycle).
  // Starts seen while Busy=1 are dropped. Q/R/flags hold until the next result.

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic             sgn_l;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic             neg_q;
  logic             neg_r;
  logic             exc_dz;
  logic             exc_ov;

  logic             sgn_op;
  logic             ov_case;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             diff_msb_unused;

`ifdef DIV_SIGNED_EN
  assign sgn_op  = sgn_l;
  assign ov_case = sgn_l && (a_l == MIN_NEG) && (b_l == '1);
`else
  logic sgn_unused;
  assign sgn_unused = sgn_l;
  assign sgn_op     = 1'b0;
  assign ov_case    = 1'b0;
`endif

  assign a_neg = sgn_op & a_l[WIDTH-1];
  assign b_neg = sgn_op & b_l[WIDTH-1];

  // Partial remainder shifted left with the next dividend bit entering at the LSB.
  assign rem_sh = {rem, dvd[WIDTH-1]};

  sub_33bit u_sub (
    .a      (rem_sh),
    .b      ({1'b0, dsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  // A successful trial result is always below the divisor, so bit 32 is zero.
  assign diff_msb_unused = diff[WIDTH];

  assign Busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_l      <= '0;
      b_l      <= '0;
      sgn_l    <= 1'b0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      exc_dz   <= 1'b0;
      exc_ov   <= 1'b0;
      Done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      DivZero  <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            a_l      <= A;
            b_l      <= B;
            sgn_l    <= Signed;
            DivZero  <= 1'b0;
            Overflow <= 1'b0;
            exc_dz   <= 1'b0;
            exc_ov   <= 1'b0;
            state    <= ST_PREP;
          end
        end

        // Exceptions stage their fixed result and still pass through FIX so
        // that every result is published from one place.
        ST_PREP: begin
          if (b_l == '0) begin
            exc_dz <= 1'b1;
            dvd    <= DIVZERO_Q;
            rem    <= a_l;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            state  <= ST_FIX;
          end else if (ov_case) begin
            exc_ov <= 1'b1;
            dvd    <= MIN_NEG;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            state  <= ST_FIX;
          end else begin
            dvd   <= neg_if(a_l, a_neg);
            dsr   <= neg_if(b_l, b_neg);
            rem   <= '0;
            cnt   <= CNT_LAST;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            state <= ST_ITER;
          end
        end

        // The dividend register doubles as the quotient: bits shift out at the
        // top into the remainder while quotient bits shift in at the bottom.
        ST_ITER: begin
          if (!borrow) begin
            rem <= diff[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          Q        <= neg_if(dvd, neg_q);
          R        <= neg_if(rem, neg_r);
          DivZero  <= exc_dz;
          Overflow <= exc_ov;
          Done     <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
